// File: rtl/mic_sample_fifo.sv
// Timestamping FWFT sample FIFO behind the microphone CIC decimator, with an
// armable threshold detector that latches the first loud sample and its time.
module mic_sample_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 32,
    parameter int TS_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_in_valid,
    input  logic [DATA_W-1:0]     threshold,
    input  logic                  arm,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic [TS_W-1:0]       rd_ts,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic                  event_valid,
    output logic [TS_W-1:0]       event_ts,
    output logic [DATA_W-1:0]     event_sample,
    output logic [1:0]            dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_HIT   = 2'd2;

    logic [TS_W-1:0]        r_ts_cnt;
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_level;
    logic                   r_overflow;
    logic [DATA_W+TS_W-1:0] r_mem [DEPTH];
    logic [1:0]             r_state;
    logic                   r_event_valid;
    logic [TS_W-1:0]        r_event_ts;
    logic [DATA_W-1:0]      r_event_sample;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_loud;
    logic [DATA_W+TS_W-1:0] w_head;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);
    assign w_pop   = rd_en && !w_empty;
    // A write into a full FIFO is only accepted when the same edge frees a slot.
    assign w_push  = data_in_valid && (!w_full || w_pop);
    assign w_drop  = data_in_valid && w_full && !w_pop;
    assign w_loud  = data_in_valid && (data_in > threshold);
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts_cnt   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_drop)            r_overflow <= 1'b1;
            else if (clr_overflow) r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wr_ptr] <= {data_in, r_ts_cnt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_event_valid  <= 1'b0;
            r_event_ts     <= '0;
            r_event_sample <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HIT: begin
                    if (arm) begin
                        r_state       <= S_ARMED;
                        r_event_valid <= 1'b0;
                    end
                end
                S_ARMED: begin
                    // A re-arm pulse takes priority over evaluating the sample.
                    if (!arm && w_loud) begin
                        r_state        <= S_HIT;
                        r_event_valid  <= 1'b1;
                        r_event_ts     <= r_ts_cnt;
                        r_event_sample <= data_in;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data      = w_empty ? '0 : w_head[DATA_W+TS_W-1:TS_W];
    assign rd_ts        = w_empty ? '0 : w_head[TS_W-1:0];
    assign empty        = w_empty;
    assign full         = w_full;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign event_valid  = r_event_valid;
    assign event_ts     = r_event_ts;
    assign event_sample = r_event_sample;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_mic_sample_fifo.sv
// Directed bench for mic_sample_fifo: ordering, timestamps, full/overflow,
// empty reads, event capture and mid-operation reset.
module tb_mic_sample_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic [31:0] threshold;
    logic        arm;
    logic        rd_en;
    logic [31:0] rd_data;
    logic [31:0] rd_ts;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic        overflow;
    logic        clr_overflow;
    logic        event_valid;
    logic [31:0] event_ts;
    logic [31:0] event_sample;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [31:0] saved_ts;

    mic_sample_fifo #(.DEPTH_LOG2(4), .DATA_W(32), .TS_W(32)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .threshold(threshold), .arm(arm), .rd_en(rd_en), .rd_data(rd_data),
        .rd_ts(rd_ts), .empty(empty), .full(full), .level(level),
        .overflow(overflow), .clr_overflow(clr_overflow),
        .event_valid(event_valid), .event_ts(event_ts),
        .event_sample(event_sample), .dbg_state(dbg_state)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push(input logic [31:0] d);
        data_in       = d;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) push(base + 32'(i));
    endtask

    initial begin
        rst = 1'b1; data_in = '0; data_in_valid = 1'b0; threshold = '0;
        arm = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;

        // reset state
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_evt", event_valid, 0);
        check("rst_evts", event_sample, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_state", dbg_state, 0);

        // three spaced samples, timestamps equal the strobe cycle
        wait_until(3);  push(32'h11);
        check("t1_empty_fall", empty, 0);
        wait_until(10); push(32'h22);
        wait_until(17); push(32'h33);
        check("t1_level", level, 3);
        check("t1_d0", rd_data, 32'h11); check("t1_ts0", rd_ts, 3);  pop();
        check("t1_d1", rd_data, 32'h22); check("t1_ts1", rd_ts, 10); pop();
        check("t1_d2", rd_data, 32'h33); check("t1_ts2", rd_ts, 17); pop();
        check("t1_empty", empty, 1);

        // fill, overflow drop, drain, clear
        fill(32'h100, 16);
        check("t2_full", full, 1);
        check("t2_level", level, 16);
        check("t2_ovf_pre", overflow, 0);
        push(32'hDEAD);
        check("t2_ovf", overflow, 1);
        check("t2_level_drop", level, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_d%0d", i), rd_data, 32'h100 + 32'(i));
            pop();
        end
        check("t2_empty", empty, 1);
        check("t2_ovf_sticky", overflow, 1);
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        check("t2_ovf_clr", overflow, 0);

        // simultaneous push and pop while full
        fill(32'h200, 16);
        data_in = 32'hBEEF; data_in_valid = 1'b1; rd_en = 1'b1;
        tick();
        data_in_valid = 1'b0; rd_en = 1'b0;
        check("t3_level", level, 16);
        check("t3_ovf", overflow, 0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t3_d%0d", i), rd_data, 32'h200 + 32'(i));
            pop();
        end
        check("t3_last", rd_data, 32'hBEEF);
        pop();
        check("t3_empty", empty, 1);

        // reads on empty are ignored
        repeat (3) pop();
        check("t4_empty", empty, 1);
        check("t4_level", level, 0);
        check("t4_rd_data", rd_data, 0);
        check("t4_rd_ts", rd_ts, 0);
        saved_ts = 32'(cyc);
        push(32'h77);
        check("t4_d", rd_data, 32'h77);
        check("t4_ts", rd_ts, saved_ts);
        check("t4_level1", level, 1);
        pop();

        // threshold event capture
        threshold = 32'd1000;
        pulse_arm();
        check("t5_armed", dbg_state, 1);
        push(32'd500);
        check("t5_500", event_valid, 0);
        push(32'd1000);
        check("t5_1000", event_valid, 0);
        saved_ts = 32'(cyc);
        push(32'd1001);
        check("t5_valid", event_valid, 1);
        check("t5_sample", event_sample, 32'd1001);
        check("t5_ts", event_ts, saved_ts);
        check("t5_hit", dbg_state, 2);
        push(32'd2000);
        check("t5_hold", event_sample, 32'd1001);
        check("t5_hold_ts", event_ts, saved_ts);
        pulse_arm();
        check("t5_rearm_clr", event_valid, 0);
        saved_ts = 32'(cyc);
        push(32'd2000);
        check("t5_recap", event_sample, 32'd2000);
        check("t5_recap_ts", event_ts, saved_ts);
        check("t5_recap_v", event_valid, 1);

        // mid-operation reset
        repeat (5) pop();
        check("t6_drained", empty, 1);
        fill(32'h300, 16);
        push(32'h999);
        repeat (11) pop();
        pulse_arm();
        check("t6_pre_level", level, 5);
        check("t6_pre_ovf", overflow, 1);
        check("t6_pre_state", dbg_state, 1);
        rst = 1'b1;
        tick();
        check("t6_level", level, 0);
        check("t6_empty", empty, 1);
        check("t6_ovf", overflow, 0);
        check("t6_evt", event_valid, 0);
        check("t6_state", dbg_state, 0);
        rst = 1'b0;
        cyc = 0;
        push(32'h55);
        check("t6_d", rd_data, 32'h55);
        check("t6_ts0", rd_ts, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
